// File: rtl/if_id_stage.sv
// IF/ID pipeline register with stall, flush and a one-entry hold buffer for
// instructions returned during a stall. Define IF_ID_BUBBLE_COUNT_EN to add stall/bubble counters.
module if_id_stage #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_inst,
    input  logic             if_inst_vld,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc4,
    output logic [31:0]      id_inst,
    output logic             id_valid
`ifdef IF_ID_BUBBLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;
    logic [31:0] r_id_inst;
    logic        r_id_valid;
    logic [31:0] r_hold_inst;
    logic        r_hold_vld;

    logic [31:0] w_inst_sel;
    logic        w_have;
    logic        w_stall;
    logic        w_load_ok;

    always_comb begin
        w_inst_sel = r_hold_vld ? r_hold_inst : if_inst;
        w_have     = r_hold_vld | if_inst_vld;
        w_stall    = ~en & ~flush;
        w_load_ok  = if_valid & w_have;
    end

    // Priority: flush > stall > load; flush leaves id_pc/id_pc4 untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_pc     <= '0;
            r_id_pc4    <= '0;
            r_id_inst   <= NOP_INST;
            r_id_valid  <= 1'b0;
            r_hold_inst <= NOP_INST;
            r_hold_vld  <= 1'b0;
        end else if (flush) begin
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
            r_hold_vld <= 1'b0;
        end else if (!en) begin
            if (!r_hold_vld && if_inst_vld) begin
                r_hold_inst <= if_inst;
                r_hold_vld  <= 1'b1;
            end
        end else begin
            r_id_pc    <= if_pc;
            r_id_pc4   <= if_pc + PC_INC;
            r_id_inst  <= w_load_ok ? w_inst_sel : NOP_INST;
            r_id_valid <= w_load_ok;
            r_hold_vld <= 1'b0;
        end
    end

    assign id_pc    = r_id_pc;
    assign id_pc4   = r_id_pc4;
    assign id_inst  = r_id_inst;
    assign id_valid = r_id_valid;

`ifdef IF_ID_BUBBLE_COUNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_bubble;

    always_comb begin
        w_bubble = flush | (en & ~w_load_ok);
    end

    // Saturating counters: hold at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_bubble && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed cases plus random traffic
// compared against a queue-based behavioural model.
module tb_if_id_stage;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam int unsigned TB_CNT_W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_inst = '0;
    logic        if_inst_vld = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic        id_valid;
`ifdef IF_ID_BUBBLE_COUNT_EN
    logic [TB_CNT_W-1:0] stall_cnt;
    logic [TB_CNT_W-1:0] bubble_cnt;
`endif

    if_id_stage #(
        .NOP_INST (NOP),
        .PC_INC   (32'd4),
        .CNT_W    (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .flush       (flush),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_inst_vld (if_inst_vld),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .id_inst     (id_inst),
        .id_valid    (id_valid)
`ifdef IF_ID_BUBBLE_COUNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [31:0] m_pc, m_pc4, m_inst;
    logic        m_valid;
    logic [31:0] m_hold[$];
    int unsigned m_stall, m_bubble;
    int unsigned cnt_max = (1 << TB_CNT_W) - 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_pc4 = '0; m_inst = NOP; m_valid = 1'b0;
        m_hold.delete();
        m_stall = 0; m_bubble = 0;
    endtask

    task automatic bump_bubble();
        if (m_bubble < cnt_max) m_bubble++;
    endtask

    task automatic model_edge();
        if (flush) begin
            m_valid = 1'b0;
            m_inst  = NOP;
            m_hold.delete();
            bump_bubble();
        end else if (!en) begin
            if (m_stall < cnt_max) m_stall++;
            if (if_inst_vld && m_hold.size() == 0) m_hold.push_back(if_inst);
        end else begin
            m_pc  = if_pc;
            m_pc4 = if_pc + 32'd4;
            if (if_valid && (m_hold.size() > 0 || if_inst_vld)) begin
                m_inst  = (m_hold.size() > 0) ? m_hold[0] : if_inst;
                m_valid = 1'b1;
            end else begin
                m_inst  = NOP;
                m_valid = 1'b0;
                bump_bubble();
            end
            m_hold.delete();
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_pc"},    64'(id_pc),    64'(m_pc));
        chk({tag, "_pc4"},   64'(id_pc4),   64'(m_pc4));
        chk({tag, "_inst"},  64'(id_inst),  64'(m_inst));
        chk({tag, "_valid"}, 64'(id_valid), 64'(m_valid));
`ifdef IF_ID_BUBBLE_COUNT_EN
        chk({tag, "_scnt"},  64'(stall_cnt),  64'(m_stall));
        chk({tag, "_bcnt"},  64'(bubble_cnt), 64'(m_bubble));
`endif
    endtask

    task automatic drive(input logic e, input logic f, input logic v,
                         input logic [31:0] pc, input logic [31:0] inst, input logic s);
        en = e; flush = f; if_valid = v; if_pc = pc; if_inst = inst; if_inst_vld = s;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    // Assert reset between edges, check the immediate effect, release on negedge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // 1: first load after reset
        drive(1, 0, 1, 32'h100, 32'h2001_0005, 1);
        step("t1");
        chk("t1_pc_k",   64'(id_pc),   64'h100);
        chk("t1_pc4_k",  64'(id_pc4),  64'h104);
        chk("t1_inst_k", 64'(id_inst), 64'h2001_0005);

        // 2: stall capture, first strobe wins
        drive(0, 0, 1, 32'h104, 32'hAAAA_0001, 1);
        step("t2a");
        drive(0, 0, 1, 32'h104, 32'hBBBB_0002, 1);
        step("t2b");
        chk("t2_hold_k", 64'(id_inst), 64'h2001_0005);
        drive(1, 0, 1, 32'h104, 32'hCCCC_0003, 0);
        step("t2c");
        chk("t2_load_k", 64'(id_inst), 64'hAAAA_0001);
        chk("t2_vld_k",  64'(id_valid), 64'h1);

        // 3: flush during stall with full hold buffer
        drive(0, 0, 1, 32'h108, 32'hDDDD_0004, 1);
        step("t3a");
        drive(0, 1, 1, 32'h108, 32'hDDDD_0005, 0);
        step("t3b");
        chk("t3_flush_k", 64'(id_valid), 64'h0);
        drive(1, 0, 1, 32'h10C, 32'hEEEE_0006, 0);
        step("t3c");
        chk("t3_bub_k", 64'(id_valid), 64'h0);

        // 4: PC+4 wraps
        drive(1, 0, 1, 32'hFFFF_FFFC, 32'h1234_5678, 1);
        step("t4");
        chk("t4_wrap_k", 64'(id_pc4), 64'h0);

        // 5: fetch valid but no instruction
        drive(1, 0, 1, 32'h200, 32'h5555_5555, 0);
        step("t5");
        chk("t5_inst_k", 64'(id_inst), 64'(NOP));

`ifdef IF_ID_BUBBLE_COUNT_EN
        // 6: counter saturation
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 32'h300, 32'h0, 0);
            step("t6s");
        end
        chk("t6_scnt_k", 64'(stall_cnt), 64'h3);
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 32'h300, 32'h0, 1);
            step("t6b");
        end
        chk("t6_bcnt_k", 64'(bubble_cnt), 64'h2);
        do_reset();
        chk("t6_rst_k", 64'(stall_cnt), 64'h0);
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 8, pc, $urandom, $urandom_range(0, 1) == 1);
            step("rnd");
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
